// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: oversampling UART receiver, recovers 8N1 frames onto an AXI-stream byte port.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_deframer #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rxd,
  input  logic [15:0]           prescale,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  frame_error,
  output logic                  overrun_error,
  output logic                  parity_error
);

  localparam int CNT_W = 19;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [15:0]            p_q, p_d;
  logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic                   tvalid_q, tvalid_d;
  logic                   busy_q, busy_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   parity_err_q, parity_err_d;
`endif

  logic                   rxs;
  logic                   sample;
  logic                   good;
  logic [15:0]            p_eff;
  logic [CNT_W-1:0]       half_load;
  logic [CNT_W-1:0]       bit_load;

  assign rxs       = sync_q[SYNC_STAGES-1];
  assign sync_d    = {sync_q[SYNC_STAGES-2:0], rxd};
  assign sample    = (cnt_q == '0);
  // A zero prescale would never reach a sample point, so it runs as prescale 1.
  assign p_eff     = (prescale == 16'd0) ? 16'd1 : prescale;
  assign half_load = CNT_W'({p_eff, 2'b00}) - CNT_W'(1);
  assign bit_load  = CNT_W'({p_q, 3'b000}) - CNT_W'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, otherwise paths that skip it infer latches.
    state_d     = state_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q & ~m_axis_tready;
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    good        = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (!rxs) begin
          p_d       = p_eff;
          cnt_d     = half_load;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          state_d   = ST_START;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end

      ST_START: begin
        if (sample) begin
          if (rxs) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d   = bit_load;
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (sample) begin
          shift_d   = {rxs, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          cnt_d     = bit_load;
          if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample) begin
          par_bad_d = rxs ^ (^shift_q);
          cnt_d     = bit_load;
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif

      ST_STOP: begin
        if (sample) begin
          // Back to IDLE at mid-stop; IDLE simply waits out the rest of the stop bit.
          state_d     = ST_IDLE;
          busy_d      = 1'b0;
          frame_err_d = ~rxs;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
          good         = rxs & ~par_bad_q;
`else
          good         = rxs;
`endif
          if (good) begin
            tdata_d   = shift_q;
            tvalid_d  = 1'b1;
            overrun_d = tvalid_q & ~m_axis_tready;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= '1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      p_q          <= 16'd1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = busy_q;
  assign frame_error   = frame_err_q;
  assign overrun_error = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error  = parity_err_q;
`else
  assign parity_error  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: timing, false start, frame error, overrun, reset abort, parity.
module tb_uart_rx_deframer;

  localparam int P   = 4;
  localparam int BIT = 8 * P;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Busy rise is T0+1, tvalid rise is stop sample+1: both sides shift by one.
  localparam int STOP_OFS = 4 * P + 8 * P * (NBITS - 1);

  logic        clk = 1'b0;
  logic        reset;
  logic        rxd;
  logic [15:0] prescale;
  logic        tready;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        busy;
  logic        frame_error;
  logic        overrun_error;
  logic        parity_error;

  uart_rx_deframer #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxd           (rxd),
    .prescale      (prescale),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .busy          (busy),
    .frame_error   (frame_error),
    .overrun_error (overrun_error),
    .parity_error  (parity_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled mid-cycle.
  int         busy_rise_cyc = 0;
  int         tv_rise_cyc   = 0;
  int         tv_cycles     = 0;
  int         busy_cycles   = 0;
  int         fe_cnt        = 0;
  int         ov_cnt        = 0;
  int         pe_cnt        = 0;
  int         acc_cnt       = 0;
  logic [7:0] last_acc      = 8'h00;
  logic       busy_prev     = 1'b0;
  logic       tv_prev       = 1'b0;

  always @(negedge clk) begin
    if (busy && !busy_prev) busy_rise_cyc = cyc;
    if (tvalid && !tv_prev) tv_rise_cyc = cyc;
    if (tvalid) tv_cycles++;
    if (busy) busy_cycles++;
    if (frame_error) fe_cnt++;
    if (overrun_error) ov_cnt++;
    if (parity_error) pe_cnt++;
    if (tvalid && tready) begin
      acc_cnt++;
      last_acc = tdata;
    end
    busy_prev = busy;
    tv_prev   = tvalid;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int s_tv, s_busy, s_fe, s_ov, s_pe, s_acc;
  task automatic snap();
    s_tv   = tv_cycles;
    s_busy = busy_cycles;
    s_fe   = fe_cnt;
    s_ov   = ov_cnt;
    s_pe   = pe_cnt;
    s_acc  = acc_cnt;
  endtask

  task automatic hold_bit(input logic v);
    rxd = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) hold_bit(bits[i]);
    rxd = 1'b1;
    repeat (4 * BIT) @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    return {4'b0000, stop, ^d, d, 1'b0};
`else
    return {5'b00000, stop, d, 1'b0};
`endif
  endfunction

  int drive_cyc;

  initial begin
    reset    = 1'b0;
    rxd      = 1'b1;
    tready   = 1'b1;
    prescale = 16'(P);
    repeat (3) @(posedge clk);
    #1;
    check("rst_tdata", 32'(tdata), 32'h0);
    check("rst_tvalid", 32'(tvalid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_errs", {29'b0, frame_error, overrun_error, parity_error}, 32'h0);
    reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Frame 0xA5 with tready=1: latency and busy window.
    snap();
    drive_cyc = cyc;
    send_bits(frame(8'hA5, 1'b1), NBITS);
    check("a5_sync_lat", 32'(busy_rise_cyc - drive_cyc), 32'd3);
    check("a5_tv_ofs", 32'(tv_rise_cyc - busy_rise_cyc), 32'(STOP_OFS));
    check("a5_busy_len", 32'(busy_cycles - s_busy), 32'(STOP_OFS));
    check("a5_tv_len", 32'(tv_cycles - s_tv), 32'd1);
    check("a5_data", 32'(last_acc), 32'hA5);
    check("a5_errs", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov) + (pe_cnt - s_pe)), 32'd0);

    // Glitch of 8 cycles: false start, busy only until the start sample.
    snap();
    rxd = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rxd = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("gl_busy_len", 32'(busy_cycles - s_busy), 32'd16);
    check("gl_busy", 32'(busy), 32'd0);
    check("gl_tv", 32'(tv_cycles - s_tv), 32'd0);
    check("gl_errs", 32'((fe_cnt - s_fe) + (ov_cnt - s_ov) + (pe_cnt - s_pe)), 32'd0);

    // 0x3C with bad stop bit, then good 0x11.
    snap();
    send_bits(frame(8'h3C, 1'b0), NBITS);
    check("fe_pulses", 32'(fe_cnt - s_fe), 32'd1);
    check("fe_tv", 32'(tv_cycles - s_tv), 32'd0);
    check("fe_busy", 32'(busy), 32'd0);
    snap();
    send_bits(frame(8'h11, 1'b1), NBITS);
    check("fe_next_cnt", 32'(acc_cnt - s_acc), 32'd1);
    check("fe_next_data", 32'(last_acc), 32'h11);

    // Back-to-back 0x12, 0x34 with tready=0.
    tready = 1'b0;
    snap();
    send_bits(frame(8'h12, 1'b1), NBITS);
    check("ov1_data", 32'(tdata), 32'h12);
    check("ov1_tv", 32'(tvalid), 32'd1);
    check("ov1_flag", 32'(ov_cnt - s_ov), 32'd0);
    send_bits(frame(8'h34, 1'b1), NBITS);
    check("ov2_data", 32'(tdata), 32'h34);
    check("ov2_tv", 32'(tvalid), 32'd1);
    check("ov2_flag", 32'(ov_cnt - s_ov), 32'd1);
    tready = 1'b1;
    @(posedge clk);
    #1;
    tready = 1'b0;
    check("ov_drain_tv", 32'(tvalid), 32'd0);
    check("ov_drain_data", 32'(last_acc), 32'h34);
    tready = 1'b1;

    // Reset during data bit 3 of 0xFF.
    hold_bit(1'b0);
    for (int i = 0; i < 3; i++) hold_bit(1'b1);
    rxd = 1'b1;
    repeat (BIT / 2) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_tdata", 32'(tdata), 32'h0);
    check("mid_rst_tv_busy", {30'b0, tvalid, busy}, 32'h0);
    check("mid_rst_errs", {29'b0, frame_error, overrun_error, parity_error}, 32'h0);
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    snap();
    send_bits(frame(8'h5A, 1'b1), NBITS);
    check("post_rst_cnt", 32'(acc_cnt - s_acc), 32'd1);
    check("post_rst_data", 32'(last_acc), 32'h5A);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so even parity needs a 1.
    snap();
    send_bits({4'b0000, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    check("par_bad_pulse", 32'(pe_cnt - s_pe), 32'd1);
    check("par_bad_tv", 32'(tv_cycles - s_tv), 32'd0);
    snap();
    send_bits({4'b0000, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    check("par_ok_cnt", 32'(acc_cnt - s_acc), 32'd1);
    check("par_ok_data", 32'(last_acc), 32'h07);
    check("par_ok_pe", 32'(pe_cnt - s_pe), 32'd0);
`else
    check("no_parity_err", 32'(pe_cnt), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
- Receive-side UART deframer: oversamples the asynchronous rxd line, recovers 8N1 frames and presents each byte on an AXI-stream style master port.
- Sits directly upstream of the two-operand controller, which counts received bytes from tdata/tvalid.
- Uses the same prescale convention as the rest of the UART path: prescale = f_clk / (baud × 8), e.g. 100 MHz / (115200 × 8) = 108.

Parameters:
- DATA_WIDTH, 8: data bits per frame, LSB first.
- SYNC_STAGES, 2: flip-flop stages in the rxd synchronizer (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- rxd  input  1  serial line; idles high.
- prescale  input  16  clock cycles per 1/8 bit; latched at start detect.
- m_axis_tdata  output  DATA_WIDTH  received byte.
- m_axis_tvalid  output  1  byte available.
- m_axis_tready  input  1  consumer accepts byte.
- busy  output  1  frame reception in progress.
- frame_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun_error  output  1  one-cycle pulse: new byte arrived while previous one was unaccepted.
- parity_error  output  1  one-cycle pulse: parity mismatch (PARITY_EN only; tied 0 otherwise).

Behaviour:
- Reset values (async, while reset=0):
  - m_axis_tdata=0, m_axis_tvalid=0, busy=0, all error outputs 0.
  - Synchronizer flops = 1; state = IDLE.
- Synchronizer: rxd passes through SYNC_STAGES flops; all decisions use the synchronized value rxs.
- Prescale: P = latched prescale; P=0 is treated as 1. Bit period = 8P cycles.
- Timing: let T0 = first cycle rxs=0 while in IDLE. Sample points fall at T0 + 4P + 8P·k:
  - k=0: start bit.
  - k=1..DATA_WIDTH: data bits, LSB first.
  - Next k: parity bit (PARITY_EN only).
  - Last k: stop bit.
- States:
  - IDLE: busy=0. When rxs=0, latch P, load counter 4P-1 and go to START; busy=1 from the next cycle.
  - START: at the sample point, if rxs=1 this is a false start: return to IDLE with no output and no error. If rxs=0, reload counter 8P-1 and go to DATA.
  - DATA: shift rxs into the shift register at each sample point. After DATA_WIDTH bits, go to PARITY (if enabled) or STOP.
  - PARITY: sample the bit and compare against even parity of the data. Record any mismatch, then go to STOP.
  - STOP: at the sample point:
    - rxs=0: pulse frame_error; byte discarded.
    - Parity mismatch recorded: pulse parity_error; byte discarded.
    - Otherwise: deliver the byte (see handshake).
    - Return to IDLE in the same cycle. The remaining half stop bit is absorbed by IDLE waiting for the next low.
- Handshake: tvalid rises the cycle after the stop sample and holds, with tdata stable, until a cycle where tvalid && tready. tvalid drops the next cycle.
- Overrun: a new byte delivered while tvalid=1 and tready=0 overwrites tdata, keeps tvalid=1 and pulses overrun_error. If tready=1 in that same cycle, the old byte counts as accepted and no overrun is flagged.
- Concurrency: reception continues regardless of tready; there is no backpressure onto the line.
- Prescale changes mid-frame are ignored until the next start detect.
- Reset asserted mid-frame aborts the frame immediately. After release, the block waits in IDLE for a fresh falling edge; a line already low at release is treated as a start.
- Latency: stop-bit sample to tvalid = 1 cycle; rxd pin to rxs = SYNC_STAGES cycles.

Optional Feature:
- Macro: UART_RX_PARITY_EN
- Defined:
  - Frame is start + DATA_WIDTH data + even-parity bit + stop.
  - PARITY state is present and parity_error is driven.
  - The byte is withheld when parity mismatches, even if the stop bit is good.
  - If the stop bit is also bad, both frame_error and parity_error pulse in the same cycle.
- Undefined:
  - Frame is start + data + stop.
  - No PARITY state; parity_error is constant 0.

Test Plan:
- Frame 0xA5 at prescale=4 (bit = 32 cycles), tready=1:
  - tdata=0xA5; tvalid high exactly 1 cycle, one cycle after the stop sample at T0+4·4+8·4·9 = T0+304.
  - busy high from T0+1 to T0+304.
- Glitch: rxd low 8 cycles then high, prescale=4 → no tvalid, no errors, busy returns 0 at the start sample.
- Frame 0x3C with stop bit forced 0 → frame_error pulses once, tvalid stays 0; the next good frame 0x11 is received correctly.
- Frames 0x12 then 0x34 back-to-back with tready=0:
  - After the first: tdata=0x12, tvalid=1.
  - After the second: tdata=0x34, overrun_error pulses once.
  - Raising tready for one cycle then clears tvalid.
- Reset (0) asserted during data bit 3 of 0xFF: all outputs 0 immediately. After release, frame 0x5A is received as 0x5A.
- With UART_RX_PARITY_EN:
  - 0x07 sent with parity bit 0 → parity_error pulse, no tvalid.
  - 0x07 sent with parity bit 1 → tdata=0x07, tvalid.
